aliens_io_ctrl: RTL and testbench

//  Consumes IOCS from the k053327 D20 address decoder; handles the 0x5F80-0x5F9F I/O window.

---
 rtl/aliens_io_pkg.sv | 23 ++
 rtl/io_watchdog.sv | 60 ++++++
 rtl/aliens_io_ctrl.sv | 139 +++++++++++++
 tb/tb_aliens_io_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/aliens_io_pkg.sv
// Shared constants for the Aliens I/O window: sub-addresses and control bit positions.
package aliens_io_pkg;

    // Sub-addresses inside the 0x5F80-0x5F9F window (CPU A[3:0])
    localparam logic [3:0] SA_DSW3 = 4'h0;
    localparam logic [3:0] SA_IN1  = 4'h1;
    localparam logic [3:0] SA_IN2  = 4'h2;
    localparam logic [3:0] SA_DSW2 = 4'h3;
    localparam logic [3:0] SA_DSW1 = 4'h4;
    localparam logic [3:0] SA_CTRL = 4'h8;
    localparam logic [3:0] SA_SND  = 4'hC;

    // Control latch bit positions
    localparam int CTRL_COIN0 = 0;
    localparam int CTRL_COIN1 = 1;
    localparam int CTRL_BANK  = 5;
    localparam int CTRL_RMRD  = 6;
    localparam int CTRL_LED   = 7;

    // Value returned for unmapped reads and when the window is not selected
    localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/io_watchdog.sv
// Watchdog: down-counter reloaded by kicks; on expiry emits a fixed-length reset pulse.
module io_watchdog #(
    parameter logic [23:0] WDOG_CYCLES = 24'd2_000_000,
    parameter int          WDOG_PULSE  = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic kick_i,
    output logic timeout_o,
    output logic wdog_rst_o
);

    localparam logic [23:0] CNT_LOAD   = WDOG_CYCLES - 24'd1;
    localparam logic [15:0] PULSE_LOAD = 16'(WDOG_PULSE - 1);

    logic [23:0] cnt_q, cnt_d;
    logic [15:0] pulse_cnt_q, pulse_cnt_d;
    logic        pulse_q, pulse_d;

    // Expiry event: counter already at zero, not pulsing, and no rescuing kick this cycle
    assign timeout_o  = ~pulse_q & ~kick_i & (cnt_q == 24'd0);
    assign wdog_rst_o = pulse_q;

    // Next-state: pulse timing has priority, then kick, then expiry, then countdown
    always_comb begin
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        pulse_d     = pulse_q;
        if (pulse_q) begin
            // Counter frozen and kicks ignored while the pulse is running
            if (pulse_cnt_q == 16'd0) begin
                pulse_d = 1'b0;
                cnt_d   = CNT_LOAD;
            end else begin
                pulse_cnt_d = pulse_cnt_q - 16'd1;
            end
        end else if (kick_i) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q == 24'd0) begin
            pulse_d     = 1'b1;
            pulse_cnt_d = PULSE_LOAD;
        end else begin
            cnt_d = cnt_q - 24'd1;
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= CNT_LOAD;
            pulse_cnt_q <= 16'd0;
            pulse_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            pulse_q     <= pulse_d;
        end
    end

endmodule

// File: rtl/aliens_io_ctrl.sv
// Aliens I/O window controller: access edge detect, control latch, sound-command
// latch with IRQ handshake, input read mux and watchdog.
module aliens_io_ctrl
    import aliens_io_pkg::*;
#(
    parameter logic [23:0] WDOG_CYCLES = 24'd2_000_000,
    parameter int          WDOG_PULSE  = 16,
    parameter logic [7:0]  CTRL_RESET  = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       iocs_n_i,
    input  logic       rw_i,
    input  logic [3:0] addr_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    input  logic [7:0] dsw1_i,
    input  logic [7:0] dsw2_i,
    input  logic [7:0] dsw3_i,
    input  logic [7:0] in1_i,
    input  logic [7:0] in2_i,
    input  logic       snd_ack_i,
    output logic [1:0] coin_cnt_o,
    output logic       bank0000_o,
    output logic       rmrd_o,
    output logic       led_o,
    output logic [7:0] snd_cmd_o,
    output logic       snd_irq_o,
    output logic       wdog_rst_o
);

    // Only the control bits that drive outputs are stored
    logic [1:0] coin_q, coin_d;
    logic       bank_q, bank_d;
    logic       rmrd_q, rmrd_d;
    logic       led_q,  led_d;
    logic [7:0] snd_cmd_q, snd_cmd_d;
    logic       snd_irq_q, snd_irq_d;
    logic       iocs_n_q;
    // Set once iocs_n has been seen high after reset, so a select that was
    // already low when reset released cannot count as a fresh access.
    logic       hi_seen_q;

    logic acc, wr_acc, kick, timeout, wdog_rst, clear;

    assign acc    = ~iocs_n_i & iocs_n_q & hi_seen_q;
    assign wr_acc = acc & ~rw_i;
    assign kick   = acc & rw_i & (addr_i == SA_CTRL);
    assign clear  = timeout | wdog_rst;

    io_watchdog #(
        .WDOG_CYCLES (WDOG_CYCLES),
        .WDOG_PULSE  (WDOG_PULSE)
    ) u_wdog (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .kick_i     (kick),
        .timeout_o  (timeout),
        .wdog_rst_o (wdog_rst)
    );

    // Read mux: combinational, open bus when not a selected read
    always_comb begin
        dout_o = OPEN_BUS;
        if (~iocs_n_i & rw_i) begin
            case (addr_i)
                SA_DSW3: dout_o = dsw3_i;
                SA_IN1:  dout_o = in1_i;
                SA_IN2:  dout_o = in2_i;
                SA_DSW2: dout_o = dsw2_i;
                SA_DSW1: dout_o = dsw1_i;
                default: dout_o = OPEN_BUS;
            endcase
        end
    end

    // Latch next-state: watchdog clear beats CPU writes; a sound write beats an ack
    always_comb begin
        coin_d    = coin_q;
        bank_d    = bank_q;
        rmrd_d    = rmrd_q;
        led_d     = led_q;
        snd_cmd_d = snd_cmd_q;
        snd_irq_d = snd_irq_q;
        if (clear) begin
            coin_d    = {CTRL_RESET[CTRL_COIN1], CTRL_RESET[CTRL_COIN0]};
            bank_d    = CTRL_RESET[CTRL_BANK];
            rmrd_d    = CTRL_RESET[CTRL_RMRD];
            led_d     = CTRL_RESET[CTRL_LED];
            snd_cmd_d = 8'h00;
            snd_irq_d = 1'b0;
        end else begin
            if (wr_acc && addr_i == SA_CTRL) begin
                coin_d = {din_i[CTRL_COIN1], din_i[CTRL_COIN0]};
                bank_d = din_i[CTRL_BANK];
                rmrd_d = din_i[CTRL_RMRD];
                led_d  = din_i[CTRL_LED];
            end
            if (wr_acc && addr_i == SA_SND) begin
                snd_cmd_d = din_i;
                snd_irq_d = 1'b1;
            end else if (snd_ack_i) begin
                snd_irq_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coin_q    <= {CTRL_RESET[CTRL_COIN1], CTRL_RESET[CTRL_COIN0]};
            bank_q    <= CTRL_RESET[CTRL_BANK];
            rmrd_q    <= CTRL_RESET[CTRL_RMRD];
            led_q     <= CTRL_RESET[CTRL_LED];
            snd_cmd_q <= 8'h00;
            snd_irq_q <= 1'b0;
            iocs_n_q  <= 1'b1;
            hi_seen_q <= 1'b0;
        end else begin
            coin_q    <= coin_d;
            bank_q    <= bank_d;
            rmrd_q    <= rmrd_d;
            led_q     <= led_d;
            snd_cmd_q <= snd_cmd_d;
            snd_irq_q <= snd_irq_d;
            iocs_n_q  <= iocs_n_i;
            hi_seen_q <= hi_seen_q | iocs_n_i;
        end
    end

    assign coin_cnt_o = coin_q;
    assign bank0000_o = bank_q;
    assign rmrd_o     = rmrd_q;
    assign led_o      = led_q;
    assign snd_cmd_o  = snd_cmd_q;
    assign snd_irq_o  = snd_irq_q;
    assign wdog_rst_o = wdog_rst;

endmodule

// File: tb/tb_aliens_io_ctrl.sv
// Directed self-checking bench for aliens_io_ctrl. One instance with a long
// watchdog for the functional tests, one with an 8-cycle watchdog.
module tb_aliens_io_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Functional instance stimulus
    logic       iocs_n = 1'b1, rw = 1'b1, snd_ack = 1'b0;
    logic [3:0] addr = 4'h0;
    logic [7:0] din = 8'h00;
    logic [7:0] dsw1 = 8'h12, dsw2 = 8'hD2, dsw3 = 8'hD3, in1 = 8'hA1, in2 = 8'h34;
    logic [7:0] dout, snd_cmd;
    logic [1:0] coin_cnt;
    logic       bank0000, rmrd, led, snd_irq, wdog_rst;

    // Watchdog instance stimulus
    logic       iocs_n2 = 1'b1, rw2 = 1'b1;
    logic [3:0] addr2 = 4'h0;
    logic [7:0] din2 = 8'h00;
    logic [7:0] dout2, snd_cmd2;
    logic [1:0] coin_cnt2;
    logic       bank0000_2, rmrd2, led2, snd_irq2, wdog_rst2;

    int checks = 0;
    int failures = 0;

    aliens_io_ctrl #(.WDOG_CYCLES(24'd1000), .WDOG_PULSE(3), .CTRL_RESET(8'h00)) dut (
        .clk_i(clk), .rst_i(rst), .iocs_n_i(iocs_n), .rw_i(rw), .addr_i(addr), .din_i(din),
        .dout_o(dout), .dsw1_i(dsw1), .dsw2_i(dsw2), .dsw3_i(dsw3), .in1_i(in1), .in2_i(in2),
        .snd_ack_i(snd_ack), .coin_cnt_o(coin_cnt), .bank0000_o(bank0000), .rmrd_o(rmrd),
        .led_o(led), .snd_cmd_o(snd_cmd), .snd_irq_o(snd_irq), .wdog_rst_o(wdog_rst)
    );

    aliens_io_ctrl #(.WDOG_CYCLES(24'd8), .WDOG_PULSE(3), .CTRL_RESET(8'h00)) dut_wd (
        .clk_i(clk), .rst_i(rst), .iocs_n_i(iocs_n2), .rw_i(rw2), .addr_i(addr2), .din_i(din2),
        .dout_o(dout2), .dsw1_i(dsw1), .dsw2_i(dsw2), .dsw3_i(dsw3), .in1_i(in1), .in2_i(in2),
        .snd_ack_i(1'b0), .coin_cnt_o(coin_cnt2), .bank0000_o(bank0000_2), .rmrd_o(rmrd2),
        .led_o(led2), .snd_cmd_o(snd_cmd2), .snd_irq_o(snd_irq2), .wdog_rst_o(wdog_rst2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // 1 reset
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_rmrd", {7'd0, rmrd}, 8'h00);
        chk("rst_bank", {7'd0, bank0000}, 8'h00);
        chk("rst_coin", {6'd0, coin_cnt}, 8'h00);
        chk("rst_led", {7'd0, led}, 8'h00);
        chk("rst_irq", {7'd0, snd_irq}, 8'h00);
        chk("rst_wdog", {7'd0, wdog_rst}, 8'h00);
        chk("rst_cmd", snd_cmd, 8'h00);
        step();

        // 2 control write, then a held select must not re-trigger
        iocs_n = 1'b0; rw = 1'b0; addr = 4'h8; din = 8'hC3;
        step();
        chk("ctl_rmrd", {7'd0, rmrd}, 8'h01);
        chk("ctl_led", {7'd0, led}, 8'h01);
        chk("ctl_coin", {6'd0, coin_cnt}, 8'h03);
        chk("ctl_bank", {7'd0, bank0000}, 8'h00);
        din = 8'h00;
        for (int i = 0; i < 5; i++) step();
        chk("hold_coin", {6'd0, coin_cnt}, 8'h03);
        chk("hold_rmrd", {7'd0, rmrd}, 8'h01);
        iocs_n = 1'b1;
        step();

        // 3 sound latch and handshake
        iocs_n = 1'b0; rw = 1'b0; addr = 4'hC; din = 8'h5A;
        step();
        chk("snd_cmd", snd_cmd, 8'h5A);
        chk("snd_irq", {7'd0, snd_irq}, 8'h01);
        iocs_n = 1'b1;
        step();
        snd_ack = 1'b1;
        step();
        snd_ack = 1'b0;
        chk("ack_irq", {7'd0, snd_irq}, 8'h00);
        chk("ack_cmd", snd_cmd, 8'h5A);
        iocs_n = 1'b0; addr = 4'hC; din = 8'hA5; snd_ack = 1'b1;
        step();
        snd_ack = 1'b0; iocs_n = 1'b1;
        chk("wr_ack_irq", {7'd0, snd_irq}, 8'h01);
        chk("wr_ack_cmd", snd_cmd, 8'hA5);
        step();
        chk("wr_ack_irq2", {7'd0, snd_irq}, 8'h01);

        // 4 read mux
        iocs_n = 1'b0; rw = 1'b1; addr = 4'h4; #1;
        chk("rd_dsw1", dout, 8'h12);
        addr = 4'h2; #1;
        chk("rd_in2", dout, 8'h34);
        addr = 4'h0; #1;
        chk("rd_dsw3", dout, 8'hD3);
        addr = 4'h9; #1;
        chk("rd_a9", dout, 8'hFF);
        addr = 4'h8; #1;
        chk("rd_a8", dout, 8'hFF);
        iocs_n = 1'b1; addr = 4'h4; #1;
        chk("rd_idle", dout, 8'hFF);
        step();

        // 5a watchdog timeout with no kicks
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("wd_c1", {7'd0, wdog_rst2}, 8'h00);
        iocs_n2 = 1'b0; rw2 = 1'b0; addr2 = 4'h8; din2 = 8'hC3;
        step();
        iocs_n2 = 1'b1;
        chk("wd_ctl_set", {7'd0, rmrd2}, 8'h01);
        chk("wd_c2", {7'd0, wdog_rst2}, 8'h00);
        for (int i = 3; i <= 7; i++) begin
            step();
            chk($sformatf("wd_c%0d", i), {7'd0, wdog_rst2}, 8'h00);
        end
        for (int i = 8; i <= 10; i++) begin
            step();
            chk($sformatf("wd_c%0d", i), {7'd0, wdog_rst2}, 8'h01);
            chk($sformatf("wd_clr%0d", i), {6'd0, coin_cnt2}, 8'h00);
        end
        step();
        chk("wd_c11", {7'd0, wdog_rst2}, 8'h00);

        // 5b periodic kicks keep the watchdog quiet
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 6; k++) begin
            iocs_n2 = 1'b0; rw2 = 1'b1; addr2 = 4'h8;
            step();
            iocs_n2 = 1'b1;
            chk($sformatf("kick%0d_a", k), {7'd0, wdog_rst2}, 8'h00);
            for (int j = 0; j < 5; j++) begin
                step();
                chk($sformatf("kick%0d_%0d", k, j), {7'd0, wdog_rst2}, 8'h00);
            end
        end

        // 6 async reset mid-pulse with select held low
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 20 && !wdog_rst2; i++) step();
        chk("pulse_seen", {7'd0, wdog_rst2}, 8'h01);
        iocs_n2 = 1'b0; rw2 = 1'b0; addr2 = 4'h8; din2 = 8'hC3;
        #2;
        rst = 1'b1;
        #1;
        chk("async_wd", {7'd0, wdog_rst2}, 8'h00);
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("held_low%0d", i), {7'd0, rmrd2}, 8'h00);
        end
        iocs_n2 = 1'b1;
        step();
        iocs_n2 = 1'b0;
        step();
        iocs_n2 = 1'b1;
        chk("reselect", {7'd0, rmrd2}, 8'h01);
        chk("reselect_led", {7'd0, led2}, 8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the bench always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "time limit");
    end

endmodule
